// File: rtl/csc_frame_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : csc_frame_ctrl
// Brief    : Frame/line sequencer for the colour-space converter: pixel/line
//            coordinates, ROI gating and frame markers aligned to its output.
// Revision : 1.0 - initial release
// ============================================================================
module csc_frame_ctrl #(
    parameter int XW  = 12,
    parameter int YW  = 12,
    parameter int LAT = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_hsync,
    input  logic          in_vsync,
    input  logic          in_en,
    input  logic [XW-1:0] cfg_x0,
    input  logic [XW-1:0] cfg_x1,
    input  logic [YW-1:0] cfg_y0,
    input  logic [YW-1:0] cfg_y1,
    input  logic          cfg_valid,
    output logic          cfg_ack,
    output logic [XW-1:0] out_x,
    output logic [YW-1:0] out_y,
    output logic          out_en,
    output logic          out_roi,
    output logic          out_frame_start,
    output logic          line_err,
    output logic [15:0]   frame_cnt,
    output logic          busy
);

    localparam int CW = 2 * XW + 2 * YW;
    localparam int DW = XW + YW + 3;
    localparam logic [CW-1:0] CFG_FULL = {{XW{1'b0}}, {XW{1'b1}}, {YW{1'b0}}, {YW{1'b1}}};

    typedef enum logic [0:0] {
        WAIT_FRAME = 1'b0,
        FRAME      = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic            vs_prev_q, en_prev_q;
    logic [XW-1:0]   x_q, x_d;
    logic [YW-1:0]   y_q, y_d;
    logic [XW-1:0]   ref_len_q, ref_len_d;
    logic            ref_valid_q, ref_valid_d;
    logic            line_err_q, line_err_d;
    logic [15:0]     frame_cnt_q, frame_cnt_d;
    logic            cfg_ack_q, cfg_ack_d;
    logic            pending_q, pending_d;
    logic [CW-1:0]   stg_q, stg_d;
    logic [CW-1:0]   act_q, act_d;
    logic [DW-1:0]   dl_q [LAT];
    logic [DW-1:0]   dl_d [LAT];

    logic            w_vs_rise;
    logic            w_en_fall;
    logic            w_pix;
    logic [CW-1:0]   w_act_nxt;
    logic [XW-1:0]   w_tag_x;
    logic [YW-1:0]   w_tag_y;
    logic            w_roi;
    logic            unused_hsync;

    assign unused_hsync = in_hsync;

    assign w_vs_rise = in_vsync & ~vs_prev_q;
    assign w_en_fall = en_prev_q & ~in_en;
    assign w_pix     = in_en & (w_vs_rise | (state_q == FRAME));

    // A pixel coincident with the frame restart is the first pixel of the new frame
    assign w_act_nxt = (w_vs_rise && pending_q) ? stg_q : act_q;
    assign w_tag_x   = (w_pix && !w_vs_rise) ? x_q : '0;
    assign w_tag_y   = (w_pix && !w_vs_rise) ? y_q : '0;
    assign w_roi     = w_pix
                     & (w_act_nxt[CW-1 -: XW]    <= w_tag_x)
                     & (w_tag_x <= w_act_nxt[CW-XW-1 -: XW])
                     & (w_act_nxt[2*YW-1 -: YW]  <= w_tag_y)
                     & (w_tag_y <= w_act_nxt[YW-1:0]);

    always_comb begin
        state_d     = state_q;
        x_d         = x_q;
        y_d         = y_q;
        ref_len_d   = ref_len_q;
        ref_valid_d = ref_valid_q;
        line_err_d  = line_err_q;
        frame_cnt_d = frame_cnt_q;
        cfg_ack_d   = 1'b0;
        pending_d   = pending_q;
        stg_d       = stg_q;
        act_d       = w_act_nxt;

        if (w_vs_rise) begin
            state_d     = FRAME;
            x_d         = '0;
            y_d         = '0;
            ref_valid_d = 1'b0;
            line_err_d  = 1'b0;
            frame_cnt_d = frame_cnt_q + 16'd1;
            if (pending_q) begin
                cfg_ack_d = 1'b1;
                pending_d = 1'b0;
            end
        end else if ((state_q == FRAME) && w_en_fall) begin
            if (!ref_valid_q) begin
                ref_len_d   = x_q;
                ref_valid_d = 1'b1;
            end else if (x_q != ref_len_q) begin
                line_err_d = 1'b1;
            end
            if (y_q != '1) begin
                y_d = y_q + YW'(1);
            end
            x_d = '0;
        end

        // Staged after any apply above so a same-cycle capture waits a frame
        if (cfg_valid) begin
            stg_d     = {cfg_x0, cfg_x1, cfg_y0, cfg_y1};
            pending_d = 1'b1;
        end

        if (w_pix && (x_d != '1)) begin
            x_d = x_d + XW'(1);
        end
    end

    always_comb begin
        dl_d[0] = {w_tag_x, w_tag_y, w_pix, w_roi, w_vs_rise};
        for (int i = 1; i < LAT; i++) begin
            dl_d[i] = dl_q[i-1];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= WAIT_FRAME;
            vs_prev_q   <= 1'b0;
            en_prev_q   <= 1'b0;
            x_q         <= '0;
            y_q         <= '0;
            ref_len_q   <= '0;
            ref_valid_q <= 1'b0;
            line_err_q  <= 1'b0;
            frame_cnt_q <= '0;
            cfg_ack_q   <= 1'b0;
            pending_q   <= 1'b0;
            stg_q       <= '0;
            act_q       <= CFG_FULL;
            for (int i = 0; i < LAT; i++) begin
                dl_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            vs_prev_q   <= in_vsync;
            en_prev_q   <= in_en;
            x_q         <= x_d;
            y_q         <= y_d;
            ref_len_q   <= ref_len_d;
            ref_valid_q <= ref_valid_d;
            line_err_q  <= line_err_d;
            frame_cnt_q <= frame_cnt_d;
            cfg_ack_q   <= cfg_ack_d;
            pending_q   <= pending_d;
            stg_q       <= stg_d;
            act_q       <= act_d;
            for (int i = 0; i < LAT; i++) begin
                dl_q[i] <= dl_d[i];
            end
        end
    end

    assign out_x           = dl_q[LAT-1][DW-1 -: XW];
    assign out_y           = dl_q[LAT-1][YW+2 -: YW];
    assign out_en          = dl_q[LAT-1][2];
    assign out_roi         = dl_q[LAT-1][1];
    assign out_frame_start = dl_q[LAT-1][0];
    assign cfg_ack         = cfg_ack_q;
    assign line_err        = line_err_q;
    assign frame_cnt       = frame_cnt_q;
    assign busy            = (state_q == FRAME);

endmodule
`default_nettype wire

// File: tb/tb_csc_frame_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_csc_frame_ctrl
// Brief    : Scoreboard bench for csc_frame_ctrl: a wide and a 3-bit instance
//            share one stimulus stream and are checked against a frame model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_csc_frame_ctrl;

    localparam int XW  = 12;
    localparam int YW  = 12;
    localparam int LAT = 4;
    localparam int SXW = 3;
    localparam int SYW = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_hsync = 1'b0, in_vsync = 1'b0, in_en = 1'b0, cfg_valid = 1'b0;
    logic [11:0] cx0 = '0, cx1 = '0, cy0 = '0, cy1 = '0;

    logic        b_ack, b_en, b_roi, b_fs, b_lerr, b_busy;
    logic [11:0] b_x, b_y;
    logic [15:0] b_fcnt;
    logic        s_ack, s_en, s_roi, s_fs, s_lerr, s_busy;
    logic [2:0]  s_x, s_y;
    logic [15:0] s_fcnt;

    always #5 clk = ~clk;

    csc_frame_ctrl #(.XW(XW), .YW(YW), .LAT(LAT)) u_big (
        .clk(clk), .rst(rst), .in_hsync(in_hsync), .in_vsync(in_vsync), .in_en(in_en),
        .cfg_x0(cx0), .cfg_x1(cx1), .cfg_y0(cy0), .cfg_y1(cy1), .cfg_valid(cfg_valid),
        .cfg_ack(b_ack), .out_x(b_x), .out_y(b_y), .out_en(b_en), .out_roi(b_roi),
        .out_frame_start(b_fs), .line_err(b_lerr), .frame_cnt(b_fcnt), .busy(b_busy)
    );

    csc_frame_ctrl #(.XW(SXW), .YW(SYW), .LAT(LAT)) u_small (
        .clk(clk), .rst(rst), .in_hsync(in_hsync), .in_vsync(in_vsync), .in_en(in_en),
        .cfg_x0(cx0[SXW-1:0]), .cfg_x1(cx1[SXW-1:0]), .cfg_y0(cy0[SYW-1:0]), .cfg_y1(cy1[SYW-1:0]),
        .cfg_valid(cfg_valid), .cfg_ack(s_ack), .out_x(s_x), .out_y(s_y), .out_en(s_en),
        .out_roi(s_roi), .out_frame_start(s_fs), .line_err(s_lerr), .frame_cnt(s_fcnt), .busy(s_busy)
    );

    typedef struct {
        int cyc;
        int x;
        int y;
        bit en;
        bit roi;
        bit fs;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    // Reference model state: true (unsaturated) counts, saturated per width on use
    bit          m_in_frame, m_pv, m_pe, m_ack, m_pend;
    int          m_x, m_y;
    int          m_ref [2];
    bit          m_refv [2];
    bit          m_lerr [2];
    logic [15:0] m_fcnt;
    int          m_act [4];
    int          m_stg [4];

    always @(posedge clk) cyc = cyc + 1;

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s cyc=%0d actual=%0d expected=%0d", nm, cyc, act, exp);
        end
    endtask

    function automatic int sat(input int v, input int w);
        int mx;
        mx = (1 << w) - 1;
        return (v > mx) ? mx : v;
    endfunction

    task automatic model_reset();
        m_in_frame = 0; m_pv = 0; m_pe = 0; m_ack = 0; m_pend = 0;
        m_x = 0; m_y = 0; m_fcnt = '0;
        for (int w = 0; w < 2; w++) begin
            m_ref[w] = 0; m_refv[w] = 0; m_lerr[w] = 0;
        end
        m_act = '{0, 4095, 0, 4095};
        m_stg = '{0, 0, 0, 0};
        q0.delete();
        q1.delete();
    endtask

    task automatic step(input bit vs, input bit en, input bit cv,
                        input int c0, input int c1, input int c2, input int c3);
        bit rise, fall, pix;
        int tx, ty;
        in_vsync  = vs;
        in_en     = en;
        cfg_valid = cv;
        in_hsync  = 1'($urandom_range(0, 1));
        cx0 = 12'(c0); cx1 = 12'(c1); cy0 = 12'(c2); cy1 = 12'(c3);

        rise  = vs && !m_pv;
        fall  = !en && m_pe;
        m_ack = 0;
        if (rise) begin
            m_in_frame = 1;
            m_fcnt     = m_fcnt + 16'd1;
            m_x = 0;
            m_y = 0;
            for (int w = 0; w < 2; w++) begin
                m_refv[w] = 0;
                m_lerr[w] = 0;
            end
            if (m_pend) begin
                m_act  = m_stg;
                m_ack  = 1;
                m_pend = 0;
            end
        end else if (m_in_frame && fall) begin
            for (int w = 0; w < 2; w++) begin
                int len;
                len = sat(m_x, (w == 0) ? XW : SXW);
                if (!m_refv[w]) begin
                    m_ref[w]  = len;
                    m_refv[w] = 1;
                end else if (len != m_ref[w]) begin
                    m_lerr[w] = 1;
                end
            end
            m_y++;
            m_x = 0;
        end
        if (cv) begin
            m_stg  = '{c0, c1, c2, c3};
            m_pend = 1;
        end
        pix = m_in_frame && en;
        tx  = m_x;
        ty  = m_y;
        if (pix) m_x++;
        m_pv = vs;
        m_pe = en;

        if (pix || rise) begin
            for (int k = 0; k < 2; k++) begin
                exp_t e;
                int   xw, yw, mkx, mky;
                xw  = (k == 0) ? XW : SXW;
                yw  = (k == 0) ? YW : SYW;
                mkx = (1 << xw) - 1;
                mky = (1 << yw) - 1;
                e.cyc = cyc + LAT;
                e.en  = pix;
                e.fs  = rise;
                e.x   = pix ? sat(tx, xw) : 0;
                e.y   = pix ? sat(ty, yw) : 0;
                e.roi = pix && ((m_act[0] & mkx) <= e.x) && (e.x <= (m_act[1] & mkx))
                            && ((m_act[2] & mky) <= e.y) && (e.y <= (m_act[3] & mky));
                if (k == 0) q0.push_back(e);
                else        q1.push_back(e);
            end
        end

        @(posedge clk);
        #1;
        chk("cfg_ack", b_ack, m_ack);
        chk("cfg_ack_small", s_ack, m_ack);
        chk("frame_cnt", b_fcnt, m_fcnt);
        chk("busy", b_busy, m_in_frame);
        chk("line_err", b_lerr, m_lerr[0]);
        chk("line_err_small", s_lerr, m_lerr[1]);
    endtask

    task automatic s(input bit vs, input bit en);
        step(vs, en, 1'b0, 0, 0, 0, 0);
    endtask

    task automatic frame(input int nl, input int len, input int last, input int gap,
                         input bit cv, input int c0, input int c1, input int c2, input int c3);
        step(1'b1, 1'b0, cv, c0, c1, c2, c3);
        s(0, 0);
        s(0, 0);
        for (int l = 0; l < nl; l++) begin
            repeat ((l == nl - 1) ? last : len) s(0, 1);
            repeat (gap) s(0, 0);
        end
    endtask

    // Output monitor: every presented pixel or marker must match the next expectation
    always @(negedge clk) begin
        if (!rst) begin
            for (int k = 0; k < 2; k++) begin
                bit   pres, have;
                exp_t e;
                pres = (k == 0) ? (b_en || b_fs) : (s_en || s_fs);
                if (pres) begin
                    have = (k == 0) ? (q0.size() > 0) : (q1.size() > 0);
                    if (!have) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_output inst=%0d cyc=%0d actual=present expected=none", k, cyc);
                    end else begin
                        e = (k == 0) ? q0.pop_front() : q1.pop_front();
                        chk("out_cycle", cyc, e.cyc);
                        chk("out_en", (k == 0) ? b_en : s_en, e.en);
                        chk("out_frame_start", (k == 0) ? b_fs : s_fs, e.fs);
                        chk("out_x", (k == 0) ? b_x : s_x, e.x);
                        chk("out_y", (k == 0) ? b_y : s_y, e.y);
                        chk("out_roi", (k == 0) ? b_roi : s_roi, e.roi);
                    end
                end
            end
        end
    end

    initial begin
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_en", b_en, 0);
        chk("rst_out_x", b_x, 0);
        chk("rst_busy", b_busy, 0);
        chk("rst_frame_cnt", b_fcnt, 0);
        rst = 1'b0;

        for (int i = 0; i < 10; i++) s(0, 1'(i % 2));
        frame(3, 8, 8, 4, 0, 0, 0, 0, 0);
        step(0, 0, 1, 2, 5, 1, 1);
        frame(3, 8, 8, 4, 0, 0, 0, 0, 0);
        frame(3, 8, 8, 4, 1, 0, 3, 0, 0);
        frame(3, 8, 8, 4, 0, 0, 0, 0, 0);
        frame(3, 8, 7, 4, 0, 0, 0, 0, 0);
        frame(2, 8, 8, 4, 0, 0, 0, 0, 0);
        repeat (3) s(0, 1);
        s(1, 1);
        repeat (4) s(0, 1);
        repeat (3) s(0, 0);
        frame(2, 10, 10, 3, 0, 0, 0, 0, 0);

        s(1, 0);
        repeat (5) s(0, 1);
        #2 rst = 1'b1;
        #1;
        chk("midrst_out_en", b_en, 0);
        chk("midrst_out_x", b_x, 0);
        chk("midrst_out_y", b_y, 0);
        chk("midrst_frame_cnt", b_fcnt, 0);
        chk("midrst_busy", b_busy, 0);
        chk("midrst_small_x", s_x, 0);
        model_reset();
        in_en = 1'b0;
        in_vsync = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        for (int i = 0; i < 6; i++) s(0, 1'(i % 2));

        for (int f = 0; f < 20; f++) begin
            frame($urandom_range(1, 4), $urandom_range(1, 12), $urandom_range(1, 12),
                  $urandom_range(1, 3), 1'($urandom_range(0, 1)),
                  $urandom_range(0, 12), $urandom_range(0, 12),
                  $urandom_range(0, 4), $urandom_range(0, 4));
        end
        for (int i = 0; i < 300; i++) begin
            step(1'($urandom_range(0, 29) == 0), 1'($urandom_range(0, 9) < 7),
                 1'($urandom_range(0, 9) == 0),
                 $urandom_range(0, 12), $urandom_range(0, 12),
                 $urandom_range(0, 4), $urandom_range(0, 4));
        end

        repeat (LAT + 2) s(0, 0);
        chk("drain_q0", q0.size(), 0);
        chk("drain_q1", q1.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
